// File: rtl/tq_perm_ctrl.sv
// Transform-unit sequencer for the tq input permutation stage: latches TU config,
// counts rows in, tracks them through LAT enabled register stages and reports the last row out.
module tq_perm_ctrl #(
  parameter int LAT   = 2,
  parameter int ROW_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       transize_i,
  input  logic             inverse_i,
  output logic             busy_o,
  input  logic             row_valid_i,
  output logic             row_ready_o,
  output logic [1:0]       perm_size_o,
  output logic             perm_inv_o,
  output logic             adv_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ROW_W-1:0] out_row_o,
  output logic             out_last_o,
  output logic             done_o,
  output logic             err_o
);

  // One extra count bit so the input counter can sit at N=32 without wrapping.
  localparam int CW = ROW_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t           state;
  logic [CW-1:0]    in_cnt;
  logic [CW-1:0]    n_rows;
  logic             accept;
  logic             in_last;
  logic [LAT-1:0]   vld;
  logic [LAT-1:0]   last_pipe;
  logic [ROW_W-1:0] row_pipe [LAT];

  assign n_rows      = CW'(4) << perm_size_o;
  assign in_last     = (in_cnt == n_rows - CW'(1));
  assign busy_o      = (state != S_IDLE);
  assign adv_o       = !vld[LAT-1] || out_ready_i;
  assign row_ready_o = (state == S_RUN) && adv_o;
  assign accept      = row_valid_i && row_ready_o;
  assign out_valid_o = vld[LAT-1];
  assign out_row_o   = vld[LAT-1] ? row_pipe[LAT-1] : '0;
  assign out_last_o  = vld[LAT-1] && last_pipe[LAT-1];
  assign done_o      = (state == S_DRAIN) && out_last_o && out_ready_i;

  // The whole pipe moves together on adv_o, so the datapath stages never get out of step with the tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld       <= '0;
      last_pipe <= '0;
      for (int k = 0; k < LAT; k++) begin
        row_pipe[k] <= '0;
      end
    end else if (adv_o) begin
      vld[0]       <= accept;
      last_pipe[0] <= accept && in_last;
      row_pipe[0]  <= accept ? in_cnt[ROW_W-1:0] : '0;
      for (int k = 1; k < LAT; k++) begin
        vld[k]       <= vld[k-1];
        last_pipe[k] <= last_pipe[k-1];
        row_pipe[k]  <= row_pipe[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      in_cnt      <= '0;
      perm_size_o <= '0;
      perm_inv_o  <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      if (start_i && state != S_IDLE) begin
        err_o <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state       <= S_RUN;
            perm_size_o <= transize_i;
            perm_inv_o  <= inverse_i;
            in_cnt      <= '0;
          end
        end
        S_RUN: begin
          if (accept) begin
            in_cnt <= in_cnt + CW'(1);
            if (in_last) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (done_o) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tq_perm_ctrl.sv
// Randomized bench for tq_perm_ctrl: a transaction-level scoreboard tracks rows in/out per TU
// and checks ordering, last/done flags, config stability, backpressure rules and error flag.
module tb_tq_perm_ctrl;

  localparam int LAT   = 2;
  localparam int ROW_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic [1:0]       transize_i = 2'd0;
  logic             inverse_i = 1'b0;
  logic             busy_o;
  logic             row_valid_i = 1'b0;
  logic             row_ready_o;
  logic [1:0]       perm_size_o;
  logic             perm_inv_o;
  logic             adv_o;
  logic             out_valid_o;
  logic             out_ready_i = 1'b1;
  logic [ROW_W-1:0] out_row_o;
  logic             out_last_o;
  logic             done_o;
  logic             err_o;

  tq_perm_ctrl #(.LAT(LAT), .ROW_W(ROW_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .transize_i  (transize_i),
    .inverse_i   (inverse_i),
    .busy_o      (busy_o),
    .row_valid_i (row_valid_i),
    .row_ready_o (row_ready_o),
    .perm_size_o (perm_size_o),
    .perm_inv_o  (perm_inv_o),
    .adv_o       (adv_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_row_o   (out_row_o),
    .out_last_o  (out_last_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level model of the current TU: rows taken in, rows delivered, latched config.
  bit chk_en = 1'b0;
  bit m_busy = 1'b0;
  bit m_err = 1'b0;
  bit m_inv = 1'b0;
  int m_size = 0;
  int m_n = 0;
  int m_acc = 0;
  int m_emit = 0;
  int done_seen = 0;
  int t_start = 0;
  int t_first_acc = 0;
  int t_first_out = 0;
  int t_done = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit was_busy;
    bit exp_done;
    if (chk_en) begin
      was_busy = m_busy;
      checkOutput("busy", 32'(busy_o), 32'(m_busy));
      checkOutput("err", 32'(err_o), 32'(m_err));
      checkOutput("perm_size", 32'(perm_size_o), 32'(m_size));
      checkOutput("perm_inv", 32'(perm_inv_o), 32'(m_inv));
      checkOutput("adv", 32'(adv_o), 32'(!out_valid_o || out_ready_i));
      checkOutput("row_ready", 32'(row_ready_o),
                  32'(m_busy && (m_acc < m_n) && (!out_valid_o || out_ready_i)));
      checkOutput("inflight_max", 32'((m_acc - m_emit) <= LAT), 32'd1);
      if (out_valid_o) begin
        checkOutput("inflight", 32'(m_emit < m_acc), 32'd1);
        checkOutput("out_row", 32'(out_row_o), 32'(m_emit));
        checkOutput("out_last", 32'(out_last_o), 32'(m_emit == m_n - 1));
      end else begin
        checkOutput("out_row_idle", 32'(out_row_o), 32'd0);
        checkOutput("out_last_idle", 32'(out_last_o), 32'd0);
      end
      exp_done = out_valid_o && out_ready_i && m_busy && (m_emit == m_n - 1);
      checkOutput("done", 32'(done_o), 32'(exp_done));
      if (done_o) done_seen++;
      if (rst) begin
        m_busy = 1'b0; m_err = 1'b0; m_inv = 1'b0;
        m_size = 0; m_n = 0; m_acc = 0; m_emit = 0;
      end else begin
        if (row_valid_i && row_ready_o) begin
          if (m_acc == 0) t_first_acc = cyc;
          m_acc++;
        end
        if (out_valid_o && out_ready_i) begin
          if (m_emit == 0) t_first_out = cyc;
          m_emit++;
        end
        if (exp_done) begin
          m_busy = 1'b0;
          t_done = cyc;
        end
        if (start_i) begin
          if (was_busy) begin
            m_err = 1'b1;
          end else begin
            m_busy = 1'b1; m_size = int'(transize_i); m_inv = inverse_i;
            m_n = 4 << transize_i; m_acc = 0; m_emit = 0; t_start = cyc;
          end
        end
      end
    end
  end

  // Runs one TU; ready_mode 0=always ready, 1=toggle, 2=random. err_at pulses start_i mid-TU,
  // rst_after>0 aborts the TU with a reset once that many rows have been accepted.
  task automatic applyStimulus(input int size, input bit inv, input int valid_pct,
                               input int ready_mode, input int err_at, input int rst_after);
    int d0;
    d0 = done_seen;
    start_i = 1'b1;
    transize_i = 2'(size);
    inverse_i = inv;
    row_valid_i = ($urandom_range(99) < valid_pct);
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (done_seen != d0) return;
      if (rst_after > 0 && m_acc >= rst_after) begin
        rst = 1'b1;
        row_valid_i = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        row_valid_i = 1'b0;
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid_o), 32'd0);
        return;
      end
      row_valid_i = ($urandom_range(99) < valid_pct);
      case (ready_mode)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = k[0];
        default: out_ready_i = 1'($urandom_range(1));
      endcase
      start_i = (k == err_at);
      transize_i = 2'($urandom_range(3));
      inverse_i = 1'($urandom_range(1));
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    checkOutput("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int d;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    checkOutput("reset_busy", 32'(busy_o), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid_o), 32'd0);
    checkOutput("reset_err", 32'(err_o), 32'd0);
    checkOutput("reset_perm_size", 32'(perm_size_o), 32'd0);
    checkOutput("reset_done", 32'(done_o), 32'd0);
    @(posedge clk); #1;

    $display("[TB] test 1: 4x4 full throughput");
    applyStimulus(0, 1'b0, 100, 0, -1, 0);
    checkOutput("t1_first_acc", 32'(t_first_acc - t_start), 32'd1);
    checkOutput("t1_first_out", 32'(t_first_out - t_start), 32'(1 + LAT));
    checkOutput("t1_done", 32'(t_done - t_start), 32'(4 + LAT));
    checkOutput("t1_busy_after", 32'(busy_o), 32'd0);

    $display("[TB] test 2: 32x32 with toggling ready");
    d = done_seen;
    applyStimulus(3, 1'b0, 100, 1, -1, 0);
    checkOutput("t2_rows", 32'(m_emit), 32'd32);
    checkOutput("t2_done_cnt", 32'(done_seen - d), 32'd1);

    $display("[TB] test 3: start while busy");
    applyStimulus(1, 1'b0, 80, 2, 5, 0);
    checkOutput("t3_err", 32'(err_o), 32'd1);
    checkOutput("t3_rows", 32'(m_emit), 32'd8);

    $display("[TB] test 4: reset mid-TU");
    d = done_seen;
    applyStimulus(2, 1'b0, 100, 0, -1, 5);
    checkOutput("t4_no_done", 32'(done_seen - d), 32'd0);
    checkOutput("t4_err_cleared", 32'(err_o), 32'd0);
    applyStimulus(0, 1'b0, 100, 0, -1, 0);
    checkOutput("t4_after_done", 32'(done_seen - d), 32'd1);

    $display("[TB] test 5: back-to-back TUs");
    d = done_seen;
    applyStimulus(1, 1'b0, 90, 2, -1, 0);
    applyStimulus(0, 1'b1, 90, 2, -1, 0);
    checkOutput("t5_done_cnt", 32'(done_seen - d), 32'd2);
    checkOutput("t5_inv", 32'(perm_inv_o), 32'd1);

    $display("[TB] test 6: gappy input");
    applyStimulus(1, 1'b0, 50, 0, -1, 0);
    checkOutput("t6_rows", 32'(m_emit), 32'd8);

    $display("[TB] random TUs");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(int'($urandom_range(3)), 1'($urandom_range(1)),
                    int'($urandom_range(100, 30)), 2, -1, 0);
    end
    repeat (4) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
